// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX operand register, RAW forwarding from M/W and ALU source selection.
// Optional feature macro: EX_FORWARD_EN. When defined, operands are forwarded from Memory and
// Writeback, and stalled operands are refreshed. When undefined, ForwardAE/BE read 00 and a
// stall simply holds the E register.
module ex_operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [RADDR-1:0] Rs1D,
  input  logic [RADDR-1:0] Rs2D,
  input  logic [RADDR-1:0] RdD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ALUSrcAD,
  input  logic             ValidD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [RADDR-1:0] RdM,
  input  logic [RADDR-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ResultW,
  output logic [XLEN-1:0]  SrcAE,
  output logic [XLEN-1:0]  SrcBE,
  output logic [XLEN-1:0]  WriteDataE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [RADDR-1:0] Rs1E,
  output logic [RADDR-1:0] Rs2E,
  output logic [RADDR-1:0] RdE,
  output logic             ValidE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE
);

  logic [XLEN-1:0] rd1E;
  logic [XLEN-1:0] rd2E;
  logic            aluSrcE;
  logic [1:0]      aluSrcAE;
  logic [XLEN-1:0] fwdA;
  logic [XLEN-1:0] fwdB;

`ifdef EX_FORWARD_EN
  // Hazard detection: M is the younger producer and wins over W; x0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (ValidE) begin
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
        ForwardAE = 2'b10;
      end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
        ForwardAE = 2'b01;
      end
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
        ForwardBE = 2'b10;
      end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
        ForwardBE = 2'b01;
      end
    end
  end

  // Forwarded operand values.
  always_comb begin
    unique case (ForwardAE)
      2'b10:   fwdA = ALUResultM;
      2'b01:   fwdA = ResultW;
      default: fwdA = rd1E;
    endcase
    unique case (ForwardBE)
      2'b10:   fwdB = ALUResultM;
      2'b01:   fwdB = ResultW;
      default: fwdB = rd2E;
    endcase
  end
`else
  // Without forwarding, hazards are resolved by stalling upstream.
  logic unusedFwdInputs;
  assign unusedFwdInputs = ^{RdM, RdW, RegWriteM, RegWriteW, ALUResultM, ResultW};
  assign ForwardAE = 2'b00;
  assign ForwardBE = 2'b00;
  assign fwdA      = rd1E;
  assign fwdB      = rd2E;
`endif

  // ALU source selection; encoding 11 on ALUSrcAE behaves as rs1.
  always_comb begin
    case (aluSrcAE)
      2'b01:   SrcAE = PCE;
      2'b10:   SrcAE = '0;
      default: SrcAE = fwdA;
    endcase
    SrcBE      = aluSrcE ? ImmExtE : fwdB;
    WriteDataE = fwdB;
  end

  // E register: flush beats stall beats load; a stall refreshes operands with forwarded values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1E     <= '0;
      rd2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      aluSrcE  <= 1'b0;
      aluSrcAE <= 2'b00;
      ValidE   <= 1'b0;
    end else if (FlushE) begin
      rd1E     <= '0;
      rd2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      aluSrcE  <= 1'b0;
      aluSrcAE <= 2'b00;
      ValidE   <= 1'b0;
    end else if (StallE) begin
`ifdef EX_FORWARD_EN
      rd1E <= fwdA;
      rd2E <= fwdB;
`endif
    end else begin
      rd1E     <= RD1D;
      rd2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCE      <= PCD;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
      aluSrcE  <= ALUSrcD;
      aluSrcAE <= ALUSrcAD;
      ValidE   <= ValidD;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage; reference model follows EX_FORWARD_EN when defined.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW;
  logic        ALUSrcD, ValidD, StallE, FlushE, RegWriteM, RegWriteW;
  logic [1:0]  ALUSrcAD;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ValidE;
  logic [1:0]  ForwardAE, ForwardBE;

  ex_operand_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ALUSrcD(ALUSrcD), .ALUSrcAD(ALUSrcAD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
    .PCE(PCE), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ValidE(ValidE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  always #5 clk = ~clk;

`ifdef EX_FORWARD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, aluResM, resW;
    logic [4:0]  rs1, rs2, rd, rdM, rdW;
    logic        aluSrc, valid, stall, flush, regWriteM, regWriteW;
    logic [1:0]  aluSrcA;
  } stim_t;

  // The instruction occupying the E slot, as the model sees it.
  typedef struct {
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        aluSrc, valid;
    logic [1:0]  aluSrcA;
  } slot_t;

  typedef struct {
    logic [31:0] srcA, srcB, wdata, pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        valid;
    logic [1:0]  fwdA, fwdB;
  } exp_t;

  exp_t  expQ[$];
  slot_t cur, nxt;
  int    nCompared = 0;
  int    nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Which stage supplies a source register: the youngest writer of that register, never x0.
  function automatic logic [1:0] source(input logic slotValid, input logic [4:0] idx,
                                        input stim_t s);
    if (!FwdOn || !slotValid || idx == 5'd0) return 2'b00;
    if (s.regWriteM && s.rdM == idx) return 2'b10;
    if (s.regWriteW && s.rdW == idx) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] value(input logic [1:0] src, input logic [31:0] regVal,
                                        input stim_t s);
    if (src == 2'b10) return s.aluResM;
    if (src == 2'b01) return s.resW;
    return regVal;
  endfunction

  task automatic drive(input stim_t s);
    RD1D = s.rd1; RD2D = s.rd2; ImmExtD = s.imm; PCD = s.pc;
    Rs1D = s.rs1; Rs2D = s.rs2; RdD = s.rd;
    ALUSrcD = s.aluSrc; ALUSrcAD = s.aluSrcA; ValidD = s.valid;
    StallE = s.stall; FlushE = s.flush;
    RdM = s.rdM; RdW = s.rdW; RegWriteM = s.regWriteM; RegWriteW = s.regWriteW;
    ALUResultM = s.aluResM; ResultW = s.resW;
  endtask

  // Called at posedge+1: drive inputs, push this cycle's expectation, compute the next slot.
  task automatic apply(input stim_t s);
    exp_t        e;
    logic [31:0] a, b;
    drive(s);
    e.fwdA = source(cur.valid, cur.rs1, s);
    e.fwdB = source(cur.valid, cur.rs2, s);
    a = value(e.fwdA, cur.rd1, s);
    b = value(e.fwdB, cur.rd2, s);
    e.srcA  = (cur.aluSrcA == 2'b01) ? cur.pc : (cur.aluSrcA == 2'b10) ? 32'd0 : a;
    e.srcB  = cur.aluSrc ? cur.imm : b;
    e.wdata = b;
    e.pc = cur.pc; e.imm = cur.imm; e.rs1 = cur.rs1; e.rs2 = cur.rs2; e.rd = cur.rd;
    e.valid = cur.valid;
    expQ.push_back(e);
    if (s.flush) begin
      nxt = '{default: '0};
    end else if (s.stall) begin
      nxt = cur;
      if (FwdOn) begin
        nxt.rd1 = a;
        nxt.rd2 = b;
      end
    end else begin
      nxt = '{rd1: s.rd1, rd2: s.rd2, imm: s.imm, pc: s.pc, rs1: s.rs1, rs2: s.rs2,
              rd: s.rd, aluSrc: s.aluSrc, valid: s.valid, aluSrcA: s.aluSrcA};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cur = nxt;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom; s.pc = $urandom;
    s.aluResM = $urandom; s.resW = $urandom;
    s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
    s.rd  = 5'($urandom_range(0, 31));
    s.rdM = 5'($urandom_range(0, 3)); s.rdW = 5'($urandom_range(0, 3));
    s.aluSrc = 1'($urandom_range(0, 1)); s.aluSrcA = 2'($urandom_range(0, 3));
    s.valid = ($urandom_range(0, 3) != 0);
    s.stall = ($urandom_range(0, 3) == 0);
    s.flush = ($urandom_range(0, 7) == 0);
    s.regWriteM = 1'($urandom_range(0, 1)); s.regWriteW = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Asynchronous reset asserted mid-cycle; released one edge later, also mid-cycle.
  task automatic midReset();
    drive(randStim());
    rst_n = 1'b0;
    #1;
    check("reset ValidE", {31'd0, ValidE}, 32'd0);
    check("reset RdE", {27'd0, RdE}, 32'd0);
    check("reset SrcBE", SrcBE, 32'd0);
    cur = '{default: '0};
    nxt = cur;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("SrcAE", SrcAE, e.srcA);
        check("SrcBE", SrcBE, e.srcB);
        check("WriteDataE", WriteDataE, e.wdata);
        check("PCE", PCE, e.pc);
        check("ImmExtE", ImmExtE, e.imm);
        check("Rs1E", {27'd0, Rs1E}, {27'd0, e.rs1});
        check("Rs2E", {27'd0, Rs2E}, {27'd0, e.rs2});
        check("RdE", {27'd0, RdE}, {27'd0, e.rd});
        check("ValidE", {31'd0, ValidE}, {31'd0, e.valid});
        check("ForwardAE", {30'd0, ForwardAE}, {30'd0, e.fwdA});
        check("ForwardBE", {30'd0, ForwardBE}, {30'd0, e.fwdB});
      end
    end
  end

  initial begin
    stim_t s;
    int    waitCycles;
    rst_n = 1'b0;
    drive(idle());
    cur = '{default: '0};
    nxt = cur;
    #3;
    check("reset ValidE", {31'd0, ValidE}, 32'd0);
    check("reset RdE", {27'd0, RdE}, 32'd0);
    check("reset SrcBE", SrcBE, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic load.
    s = idle();
    s.rd1 = 32'd5; s.rd2 = 32'd7; s.imm = 32'hFFFF_FFF0; s.aluSrc = 1'b1; s.valid = 1'b1;
    s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3;
    apply(s); step();
    s = idle(); s.stall = 1'b1;
    apply(s); #1;
    check("load SrcAE", SrcAE, 32'd5);
    check("load SrcBE", SrcBE, 32'hFFFF_FFF0);
    check("load WriteDataE", WriteDataE, 32'd7);
    step();

    // Forward priority: M over W, then W alone.
    s = idle(); s.valid = 1'b1; s.rs1 = 5'd3; s.rs2 = 5'd6; s.rd1 = 32'hAAAA; s.rd = 5'd8;
    apply(s); step();
    s = idle(); s.stall = 1'b1;
    s.rdM = 5'd3; s.regWriteM = 1'b1; s.aluResM = 32'h11;
    s.rdW = 5'd3; s.regWriteW = 1'b1; s.resW = 32'h22;
    apply(s); #1;
    check("prio ForwardAE M", {30'd0, ForwardAE}, FwdOn ? 32'd2 : 32'd0);
    check("prio SrcAE M", SrcAE, FwdOn ? 32'h11 : 32'hAAAA);
    step();
    s.regWriteM = 1'b0;
    apply(s); #1;
    check("prio ForwardAE W", {30'd0, ForwardAE}, FwdOn ? 32'd1 : 32'd0);
    check("prio SrcAE W", SrcAE, FwdOn ? 32'h22 : 32'hAAAA);
    step();

    // x0 is never forwarded.
    s = idle(); s.valid = 1'b1; s.rs2 = 5'd0; s.rd2 = 32'h1234;
    apply(s); step();
    s = idle(); s.stall = 1'b1; s.rdM = 5'd0; s.regWriteM = 1'b1; s.aluResM = 32'h99;
    apply(s); #1;
    check("x0 ForwardBE", {30'd0, ForwardBE}, 32'd0);
    check("x0 WriteDataE", WriteDataE, 32'h1234);
    step();

    // Stall refresh: W retires during the stall, value must survive the next stalled cycle.
    s = idle(); s.valid = 1'b1; s.rs1 = 5'd4; s.rd1 = 32'h0BAD;
    apply(s); step();
    s = idle(); s.stall = 1'b1; s.rdW = 5'd4; s.regWriteW = 1'b1; s.resW = 32'h55;
    apply(s); #1;
    check("refresh SrcAE c1", SrcAE, FwdOn ? 32'h55 : 32'h0BAD);
    step();
    s.rdW = 5'd9; s.resW = 32'h77;
    apply(s); #1;
    check("refresh SrcAE c2", SrcAE, FwdOn ? 32'h55 : 32'h0BAD);
    check("refresh Rs1E held", {27'd0, Rs1E}, 32'd4);
    step();

    // Flush beats stall.
    s = idle(); s.valid = 1'b1; s.rd = 5'd7;
    apply(s); step();
    s = idle(); s.flush = 1'b1; s.stall = 1'b1;
    apply(s); step();
    s = idle(); s.stall = 1'b1;
    apply(s); #1;
    check("flush ValidE", {31'd0, ValidE}, 32'd0);
    check("flush RdE", {27'd0, RdE}, 32'd0);
    step();

    // Randomised traffic with one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) midReset();
      apply(randStim());
      step();
    end

    drive(idle());
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Parametrised execute-stage operand unit for the RV32I pipeline: it holds the ID/EX operand register, resolves RAW hazards by forwarding from Memory and Writeback, and selects the ALU sources (SrcAE: rs1 / PC / zero; SrcBE: rs2 / immediate). It sits between the decode stage and the ALU. It supersedes the single two-input SrcB select by adding stall/flush handling, forwarding, and operand refresh during stalls.

## Interface
Parameters:
- XLEN, 32, datapath width of operands, PC and results
- RADDR, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- RD1D, RD2D, ImmExtD, PCD  in  XLEN each  decode-stage operands
- Rs1D, Rs2D, RdD  in  RADDR each  decode-stage register indices
- ALUSrcD  in  1  1 = SrcB is the immediate
- ALUSrcAD  in  2  00 rs1, 01 PC, 10 zero (LUI), 11 treated as 00
- ValidD  in  1  decode slot holds a real instruction
- StallE  in  1  hold the E register
- FlushE  in  1  insert a bubble into E
- RdM, RdW  in  RADDR  destination registers in M and W
- RegWriteM, RegWriteW  in  1  M/W will write RdM/RdW
- ALUResultM, ResultW  in  XLEN  forwarding values
- SrcAE, SrcBE  out  XLEN  ALU operands (combinational)
- WriteDataE  out  XLEN  forwarded rs2 value for stores
- PCE, ImmExtE  out  XLEN  registered copies
- Rs1E, Rs2E, RdE  out  RADDR  registered indices
- ValidE  out  1  E slot valid
- ForwardAE, ForwardBE  out  2  00 register file, 10 from M, 01 from W

## Operation
- E register fields: RD1E, RD2E, ImmExtE, PCE, Rs1E, Rs2E, RdE, ALUSrcE, ALUSrcAE, ValidE.
- Per-edge priority: FlushE > StallE > load.
  - FlushE: all fields cleared to 0, ValidE=0.
  - StallE without FlushE: fields held, except that RD1E/RD2E are overwritten with the currently forwarded values (fwdA/fwdB). This is the operand refresh: a producer that retires from W during a stall is not lost.
  - Otherwise: the D inputs are loaded.
- Forwarding for operand A (B is identical using Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00.
  - M beats W. x0 is never forwarded.
- fwdA = ALUResultM / ResultW / RD1E per ForwardAE. fwdB is the same for rs2.
- SrcAE = fwdA, PCE or 0 per ALUSrcAE. SrcBE = ALUSrcE ? ImmExtE : fwdB. WriteDataE = fwdB.
- When ValidE=0, ForwardAE/BE are forced to 00.
- All muxes are full XLEN width with no truncation or extension. Sign extension of the immediate is done upstream.

## Timing
- Reset (rst_n low, asynchronous): every register is 0, so ValidE=0 and all registered outputs are 0. SrcAE/SrcBE/WriteDataE therefore read 0 unless M/W match index 0, which is excluded.
- D→E latency is 1 cycle. Forwarding and selection are combinational within the E cycle.
- StallE held for N cycles keeps ValidE and the indices constant. RD1E/RD2E track forwarded values each cycle.
- FlushE and StallE in the same cycle produce a bubble.
- Reset deassertion mid-stream: the first edge after release loads D normally.

## Configuration
- EX_FORWARD_EN defined: forwarding and operand refresh operate as above.
- EX_FORWARD_EN undefined:
  - ForwardAE/BE are tied to 00, and fwdA=RD1E, fwdB=RD2E.
  - Stall simply holds all fields.
  - Hazards must then be resolved by stalling.

## Test plan
- Reset: rst_n=0 mid-cycle → ValidE=0, RdE=0, SrcBE=0 immediately, without waiting for a clock edge.
- Basic load:
  - Inputs: RD1D=5, RD2D=7, ImmExtD=0xFFFFFFF0, ALUSrcD=1, ValidD=1.
  - After one edge: SrcAE=5, SrcBE=0xFFFFFFF0, WriteDataE=7.
- Forward priority:
  - Setup: Rs1E=3, with RdM=3 (ALUResultM=0x11) and RdW=3 (ResultW=0x22) both writing.
  - Expect ForwardAE=10 and SrcAE=0x11.
  - Then set RegWriteM=0: expect ForwardAE=01 and SrcAE=0x22.
- x0 guard: Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0x99 → ForwardBE=00, WriteDataE=RD2E.
- Stall refresh:
  - Setup: StallE=1 for 2 cycles, Rs1E=4, RdW=4, ResultW=0x55 in cycle 1.
  - Cycle 2: RdW unrelated.
  - Expect SrcAE=0x55 in both cycles. Without EX_FORWARD_EN, expect the original RD1E.
- Flush over stall: FlushE=1 and StallE=1 with a valid instruction in E → ValidE=0 and RdE=0 after the edge.
